// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - sequential AES key expansion, one schedule word per clock (optional KS_MASK_EN output masking)

module key_expand_seq #(
  parameter int nk = 4,
  parameter int nr = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [0:32*nk-1]      Key,
  output logic                  busy,
  output logic                  done,
  output logic [0:128*(nr+1)-1] keySchedule
);

  localparam int NW = 4 * (nr + 1);
  localparam int CW = $clog2(NW + 1);

  // FIPS-197 forward S-box, entry 0x00 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   w [0:NW-1];
  logic [CW-1:0] cnt;
  logic [2:0]    sub;
  logic [7:0]    rcon;
  logic          load;
  logic [31:0]   prev, temp;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  assign load = start && (state == IDLE || state == DONE);
  assign prev = w[cnt - CW'(1)];

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and handshake outputs; the last word write moves straight to DONE
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = EXPAND;
      end
      EXPAND: begin
        busy = 1'b1;
        if (cnt == CW'(NW - 1)) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = EXPAND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // transform applied to w[i-1]; sub is i mod nk
  always_comb begin
    temp = prev;
    if (sub == 3'd0)
      temp = sub_word({prev[23:0], prev[31:24]}) ^ {rcon, 24'h0};
    else if (nk > 6 && sub == 3'd4)
      temp = sub_word(prev);
  end

  // word array, counter, wrapping mod-nk sub-counter and Rcon register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < NW; j++) w[j] <= '0;
      cnt  <= '0;
      sub  <= '0;
      rcon <= 8'h01;
    end else if (load) begin
      // upper words keep the previous schedule until overwritten
      for (int j = 0; j < nk; j++) w[j] <= Key[32*j +: 32];
      cnt  <= CW'(nk);
      sub  <= 3'd0;
      rcon <= 8'h01;
    end else if (state == EXPAND) begin
      w[cnt] <= w[cnt - CW'(nk)] ^ temp;
      cnt    <= cnt + CW'(1);
      sub    <= (sub == 3'(nk - 1)) ? 3'd0 : sub + 3'd1;
      if (sub == 3'd0) rcon <= xtime(rcon);
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_out
`ifdef KS_MASK_EN
    assign keySchedule[32*g +: 32] = done ? w[g] : 32'h0;
`else
    assign keySchedule[32*g +: 32] = w[g];
`endif
  end

endmodule

// File: doc/key_expand_seq.md
Name: key_expand_seq

Overview:
- Sequential AES key-expansion stage that sits directly upstream of the round-based decrypt/encrypt cores.
- Takes a cipher key and produces the full round-key schedule, 128*(nr+1) bits, on a flat bus.
- Generates one 32-bit word per clock.
- Uses a start/busy/done handshake, so the consumer starts only once the schedule is stable.

Parameters:
- nk, 4, key length in 32-bit words (4, 6 or 8 → AES-128/192/256)
- nr, 10, number of rounds (10, 12 or 14; must equal nk+6)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request expansion of Key; sampled only in IDLE or DONE
- Key  input  32*nk  cipher key, big-endian, bit 0 = MSB of byte 0
- busy  output  1  high while expansion is in progress
- done  output  1  level; high while keySchedule is complete and valid
- keySchedule  output  128*(nr+1)  w[0]..w[4*(nr+1)-1], w[0] at bits [0:31]

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, word counter=0, keySchedule=0.
- States:
  - IDLE: wait for start.
  - EXPAND: write one generated word per clock.
  - DONE: schedule valid; wait for a new start.
- IDLE/DONE with start=1 at an edge:
  - Latch Key into w[0..nk-1].
  - Counter ← nk, Rcon ← 8'h01, busy ← 1, done ← 0, state ← EXPAND.
  - Words ≥ nk of the previous schedule are not cleared.
- EXPAND, each edge, for i = counter, temp = w[i-1]:
  - If i mod nk == 0: temp = SubWord(RotWord(temp)) XOR {Rcon,24'h0}. After use, Rcon ← xtime(Rcon): shift left 1, XOR 8'h1b if the MSB was set.
  - Else if nk > 6 and i mod nk == 4: temp = SubWord(temp).
  - w[i] ← w[i-nk] XOR temp; counter ← i+1.
- When i == 4*(nr+1)-1 is written: busy ← 0, done ← 1, state ← DONE, all on that same edge.
- Latency from the start-sampling edge to done high is 4*(nr+1)-nk+1 edges:
  - nk=4: 41
  - nk=6: 47
  - nk=8: 53
- i mod nk is tracked with a wrapping sub-counter, not a divider. Rcon sequence: 01 02 04 08 10 20 40 80 1b 36.
- SubWord uses 4 internal combinational S-box lookups (FIPS-197 forward S-box) on the word being generated.
- start while busy=1: ignored; the current expansion continues unchanged.
- start in DONE: restarts expansion. done drops on that same edge.
- Key changes while busy: ignored; Key is only read on the start-sampling edge.
- reset asserted mid-expansion: immediate return to reset values; schedule cleared.
- keySchedule is driven directly from the register array; there is no combinational path from Key.

Optional Feature:
- Macro: KS_MASK_EN
- Defined:
  - keySchedule reads all-zero whenever done=0, including during EXPAND.
  - A partially built schedule is never visible to consumers.
  - Internal registers are unaffected.
- Undefined:
  - keySchedule exposes the register array at all times; words are visible as they are written.
  - Consumers must qualify with done.

Test Plan:
- nk=4, nr=10, Key=000102030405060708090a0b0c0d0e0f, start 1 cycle:
  - done rises exactly 41 edges after the start edge.
  - w[4..7] = d6aa74fd d2af72fa daa678f1 d6ab76fe.
  - w[40..43] = 13111d7f e3944a17 f307a78b 4d2b30c5.
- nk=4, Key=2b7e151628aed2a6abf7158809cf4f3c → w[40]=d014f9a8, w[43]=b6630ca6.
- nk=8, nr=14, Key=000102…1f:
  - done after 53 edges.
  - w[56..59] = 24fc79cc bf0979e9 371ac23c 6d68de36 (exercises the i mod nk==4 SubWord path).
- Start pulsed again at cycle 10 of an expansion, with a different Key:
  - Ignored; the result matches the first Key.
  - A later start in DONE with the new Key drops done on that edge and produces the new schedule.
- reset asserted at cycle 20 of an expansion:
  - Asynchronously busy=0, done=0, keySchedule=0.
  - After release with no start, the outputs stay at those values.
- KS_MASK_EN defined, run the first scenario:
  - keySchedule==0 every cycle before done.
  - Once done=1, the full FIPS schedule appears.
